seq_mem_stream_loader: RTL

Front-end stage for one `seq_mem_d2` instance in the simulation harness. It fills the memory from a valid/ready word stream in row-major order, then hands the memory ports to `main` and drives `go` until `main` raises `done`. This replaces file-based `$readmemh` preloading with a cycle-accurate load phase, so load time is part of the simulated run.

---
 rtl/seq_mem_stream_loader.sv | 110 +++++++++++
 1 files changed

// File: rtl/seq_mem_stream_loader.sv
// seq_mem_stream_loader: streams D0_SIZE*D1_SIZE words row-major into a seq_mem_d2, then hands the ports to main.
// Optional checksum output enabled by defining SEQ_MEM_LOADER_CHECKSUM_EN.
module seq_mem_stream_loader #(
  parameter int D0_SIZE     = 8,
  parameter int D1_SIZE     = 8,
  parameter int D0_IDX_SIZE = 4,
  parameter int D1_IDX_SIZE = 4,
  parameter int WIDTH       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [D0_IDX_SIZE-1:0] mem_addr0,
  output logic [D1_IDX_SIZE-1:0] mem_addr1,
  output logic [WIDTH-1:0]       mem_write_data,
  output logic                   mem_write_en,
  output logic                   mem_read_en,
  input  logic                   mem_write_done,
  input  logic [D0_IDX_SIZE-1:0] main_addr0,
  input  logic [D1_IDX_SIZE-1:0] main_addr1,
  input  logic [WIDTH-1:0]       main_write_data,
  input  logic                   main_write_en,
  input  logic                   main_read_en,
  output logic                   go,
  input  logic                   main_done,
  output logic                   busy,
  output logic                   finished
`ifdef SEQ_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]       checksum
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, FIN} state_t;
  state_t state, nxt;
  logic [D0_IDX_SIZE-1:0] r;
  logic [D1_IDX_SIZE-1:0] c;
  logic [WIDTH-1:0] wdata;
  logic last_r, last_c;
  assign last_r = r == D0_IDX_SIZE'(D0_SIZE - 1);
  assign last_c = c == D1_IDX_SIZE'(D1_SIZE - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    in_ready = 1'b0;
    go = 1'b0;
    finished = 1'b0;
    mem_addr0 = '0;
    mem_addr1 = '0;
    mem_write_data = '0;
    mem_write_en = 1'b0;
    mem_read_en = 1'b0;
    case (state)
      IDLE: nxt = start ? LOAD : IDLE;
      LOAD: begin
        in_ready = 1'b1;
        nxt = in_valid ? WRITE : LOAD;
      end
      WRITE: begin
        mem_addr0 = r;
        mem_addr1 = c;
        mem_write_data = wdata;
        mem_write_en = 1'b1;
        nxt = !mem_write_done ? WRITE : (last_r && last_c) ? RUN : LOAD;
      end
      RUN: begin
        go = 1'b1;
        mem_addr0 = main_addr0;
        mem_addr1 = main_addr1;
        mem_write_data = main_write_data;
        mem_write_en = main_write_en;
        mem_read_en = main_read_en;
        nxt = main_done ? FIN : RUN;
      end
      FIN: begin
        finished = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  // Counters park at the last cell after the final write so they never exceed the array bounds.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r <= '0;
      c <= '0;
      wdata <= '0;
    end else begin
      if (state == IDLE && start) begin
        r <= '0;
        c <= '0;
      end
      if (state == LOAD && in_valid) wdata <= in_data;
      if (state == WRITE && mem_write_done && !(last_r && last_c)) begin
        c <= last_c ? '0 : c + 1'b1;
        r <= last_c ? r + 1'b1 : r;
      end
    end
`ifdef SEQ_MEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (state == LOAD && in_valid) checksum <= checksum + in_data;
`endif
endmodule
